// File: rtl/word_store_serializer_pkg.sv
// -----------------------------------------------------------------------------
// word_store_serializer_pkg
//
// Purpose:
//    Shared definitions for the store-path narrowing unit. The unit takes a
//    24-bit register value and writes it to a byte-wide data memory, either as
//    three little-endian bytes (word store) or as one byte (byte store).
//
// Contents:
//    BYTE_W      width of one memory byte lane
//    WORD_BYTES  number of bytes in a full datapath word
//    WORD_W      width of the datapath word
//    state_t     serializer FSM states (IDLE, then one state per byte lane)
//    selectByte  picks byte lane 0..2 out of a datapath word
// -----------------------------------------------------------------------------
package word_store_serializer_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 3;
    localparam int WORD_W     = BYTE_W * WORD_BYTES;

    // One state per byte lane written; IDLE is the only state that accepts
    // a new request.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        B0   = 2'd1,
        B1   = 2'd2,
        B2   = 2'd3
    } state_t;

    // Byte lane selection is written as an explicit case so that the lane
    // index never needs to be widened for a multiply-by-eight part select.
    // Lane 3 does not exist in a 24-bit word and yields zero.
    function automatic logic [BYTE_W-1:0] selectByte(
        input logic [WORD_W-1:0] value,
        input logic [1:0]        lane
    );
        logic [BYTE_W-1:0] result;
        result = '0;
        case (lane)
            2'd0:    result = value[BYTE_W-1:0];
            2'd1:    result = value[2*BYTE_W-1:BYTE_W];
            2'd2:    result = value[3*BYTE_W-1:2*BYTE_W];
            default: result = '0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/word_store_serializer_byte_fit_check.sv
// -----------------------------------------------------------------------------
// byte_fit_check
//
// Purpose:
//    Combinational test of whether a 24-bit value survives being narrowed to
//    its low byte, i.e. whether sign-extending data[7:0] reproduces the whole
//    value. A byte store of a value that does not fit is still performed, but
//    the caller reports it as a truncation.
//
// Ports:
//    i_data  in   WORD_W  value to be narrowed
//    o_fits  out  1       1 when i_data[23:8] are all copies of i_data[7]
// -----------------------------------------------------------------------------
module byte_fit_check
    import word_store_serializer_pkg::*;
(
    input  logic [WORD_W-1:0] i_data,
    output logic              o_fits
);

    // The value fits when every bit above the low byte equals the low byte's
    // sign bit, which is exactly the image of sign extension.
    assign o_fits = (i_data[WORD_W-1:BYTE_W] == {(WORD_W-BYTE_W){i_data[BYTE_W-1]}});

endmodule

// File: rtl/word_store_serializer.sv
// -----------------------------------------------------------------------------
// word_store_serializer
//
// Purpose:
//    Store-path narrowing unit between the execute-stage store path and the
//    8-bit data-memory write port. A word store is written as three
//    little-endian bytes at base, base+1, base+2 (addresses wrap modulo
//    2^ADDR_W). A byte store writes data[7:0] once and flags a truncation when
//    the value is not the sign extension of its low byte.
//
// Parameters:
//    ADDR_W     byte-address width of the data memory
//
// Ports:
//    clk        in   1       rising-edge clock
//    rst        in   1       synchronous active-high reset
//    req_valid  in   1       store request present
//    req_ready  out  1       high only while IDLE
//    req_addr   in   ADDR_W  base byte address
//    req_data   in   WORD_W  register value to store
//    req_word   in   1       1 = three-byte word store, 0 = single-byte store
//    mem_we     out  1       byte write strobe
//    mem_addr   out  ADDR_W  byte address of the current write
//    mem_wdata  out  BYTE_W  byte being written
//    mem_ready  in   1       memory takes the write when mem_we && mem_ready
//    done       out  1       one-cycle pulse once the request is fully written
//    trunc_err  out  1       pulses with done for a byte store that truncated
// -----------------------------------------------------------------------------
module word_store_serializer
    import word_store_serializer_pkg::*;
#(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_data,
    input  logic              req_word,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BYTE_W-1:0] mem_wdata,
    input  logic              mem_ready,
    output logic              done,
    output logic              trunc_err
);

    state_t              r_state;
    logic [WORD_W-1:0]   r_data;
    logic                r_word;
    logic                r_trunc;
    logic                r_memWe;
    logic [ADDR_W-1:0]   r_memAddr;
    logic [BYTE_W-1:0]   r_memWdata;
    logic                r_done;
    logic                r_truncErr;

    state_t              w_nextState;
    logic                w_fits;
    logic                w_accept;
    logic                w_advance;
    logic                w_lastByte;
    logic [1:0]          w_nextLane;
    logic [ADDR_W-1:0]   w_nextAddr;

    // The fit check looks at the incoming request so that the truncation
    // verdict can be captured in the same cycle as the data itself.
    byte_fit_check u_byteFitCheck (
        .i_data (req_data),
        .o_fits (w_fits)
    );

    // req_ready is the only combinational output: it simply reflects IDLE,
    // which lets a new request be taken in the same cycle that done pulses.
    assign req_ready  = (r_state == IDLE);
    assign w_accept   = req_valid && req_ready;
    assign w_advance  = r_memWe && mem_ready;
    assign w_nextAddr = r_memAddr + ADDR_W'(1);

    assign mem_we     = r_memWe;
    assign mem_addr   = r_memAddr;
    assign mem_wdata  = r_memWdata;
    assign done       = r_done;
    assign trunc_err  = r_truncErr;

    // The final byte is lane 0 for a byte store and lane 2 for a word store;
    // accepting it is what returns the machine to IDLE.
    always_comb begin
        w_lastByte = 1'b0;
        case (r_state)
            B0:      w_lastByte = !r_word;
            B2:      w_lastByte = 1'b1;
            default: w_lastByte = 1'b0;
        endcase
    end

    // Lane to present after the current one is accepted. Only B0 and B1 ever
    // move on to another lane; every other state leaves this unused.
    always_comb begin
        w_nextLane = 2'd0;
        case (r_state)
            B0:      w_nextLane = 2'd1;
            B1:      w_nextLane = 2'd2;
            default: w_nextLane = 2'd0;
        endcase
    end

    // Next-state selection. A byte lane state only moves when the memory has
    // actually taken the write, so a stalled memory freezes the machine for as
    // long as it likes.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = B0;
                end
            end
            B0: begin
                if (w_advance) begin
                    w_nextState = r_word ? B1 : IDLE;
                end
            end
            B1: begin
                if (w_advance) begin
                    w_nextState = B2;
                end
            end
            B2: begin
                if (w_advance) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State and registered outputs. On acceptance the first write is set up
    // straight away, so lane 0 is on the memory port in the first B0 cycle.
    // The address register doubles as the running base+k pointer: each
    // accepted non-final byte bumps it by one, which wraps naturally at the
    // top of the address space. done and trunc_err default low every cycle
    // and are raised only on the edge that retires the last byte, which makes
    // them single-cycle pulses in the first IDLE cycle. Reset drops any
    // request in flight, including a pending done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_data     <= '0;
            r_word     <= 1'b0;
            r_trunc    <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_done     <= 1'b0;
            r_truncErr <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_done     <= 1'b0;
            r_truncErr <= 1'b0;
            if (r_state == IDLE) begin
                if (w_accept) begin
                    r_data     <= req_data;
                    r_word     <= req_word;
                    r_trunc    <= !req_word && !w_fits;
                    r_memWe    <= 1'b1;
                    r_memAddr  <= req_addr;
                    r_memWdata <= req_data[BYTE_W-1:0];
                end
            end else if (w_advance) begin
                if (w_lastByte) begin
                    r_memWe    <= 1'b0;
                    r_done     <= 1'b1;
                    r_truncErr <= r_trunc;
                end else begin
                    r_memAddr  <= w_nextAddr;
                    r_memWdata <= selectByte(r_data, w_nextLane);
                end
            end
        end
    end

endmodule

// File: tb/tb_word_store_serializer.sv
// -----------------------------------------------------------------------------
// tb_word_store_serializer
//
// Purpose:
//    Scoreboard bench for word_store_serializer. The driver turns every
//    accepted request into the list of byte writes and the done/trunc verdict
//    the memory should see, computed from plain address/shift arithmetic. A
//    separate monitor consumes those lists whenever the DUT presents a write
//    or a done pulse, and also watches handshake and stall behaviour.
// -----------------------------------------------------------------------------
module tb_word_store_serializer;

    localparam int ADDR_W = 24;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [23:0]       req_data = '0;
    logic              req_word = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ready = 1'b0;
    logic              done;
    logic              trunc_err;

    int                total = 0;
    int                bad = 0;
    logic [31:0]       writeQ[$];
    bit                doneQ[$];
    int                readyMode = 1;
    bit                expectDone = 1'b0;

    word_store_serializer #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_word  (req_word),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .done      (done),
        .trunc_err (trunc_err)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Guard against a hung handshake: report and stop hard.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point shared by driver and monitor.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // A byte store truncates unless the value lies within the range reachable
    // by sign-extending one byte: 0..127 or the top 128 values of 24 bits.
    function automatic bit modelTrunc(input logic [23:0] d, input bit isWord);
        if (isWord) return 1'b0;
        return !((d < 24'h000080) || (d >= 24'hFFFF80));
    endfunction

    // Expected memory traffic for one accepted request.
    task automatic pushExpected(input logic [23:0] addr, input logic [23:0] data,
                                input bit isWord);
        int n;
        logic [23:0] a;
        logic [7:0]  b;
        n = isWord ? 3 : 1;
        for (int k = 0; k < n; k++) begin
            a = addr + 24'(k);
            b = 8'((data >> (8 * k)) & 24'hFF);
            writeQ.push_back({a, b});
        end
        doneQ.push_back(modelTrunc(data, isWord));
    endtask

    // Issue one request. Entered and left just after a rising edge. While the
    // DUT is busy, req_valid is held high with junk fields that must be
    // ignored; once req_ready is seen the real request is driven and accepted.
    task automatic applyStimulus(input logic [23:0] addr, input logic [23:0] data,
                                 input bit isWord);
        int waited;
        waited = 0;
        #1;
        while (!req_ready) begin
            req_valid = 1'b1;
            req_addr  = 24'($urandom);
            req_data  = 24'($urandom);
            req_word  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            waited++;
            if (waited > 300) begin
                checkOutput("ready_timeout", 32'(req_ready), 32'd1);
                return;
            end
        end
        req_valid = 1'b1;
        req_addr  = addr;
        req_data  = data;
        req_word  = isWord;
        @(posedge clk);
        #1;
        pushExpected(addr, data, isWord);
        req_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            req_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    // Wait until the outstanding write list has shrunk to a given size.
    task automatic waitWriteQSize(input int s);
        int waited;
        waited = 0;
        while (writeQ.size() != s) begin
            @(posedge clk);
            #1;
            waited++;
            if (waited > 500) begin
                checkOutput("drain_timeout", 32'(writeQ.size()), 32'(s));
                return;
            end
        end
    endtask

    // Monitor: on every falling edge choose mem_ready for the coming rising
    // edge, then compare what the DUT presents against the scoreboard.
    initial begin
        logic        prevStall;
        logic [23:0] prevAddr;
        logic [7:0]  prevData;
        logic [31:0] w;
        bit          t;
        prevStall = 1'b0;
        prevAddr  = '0;
        prevData  = '0;
        forever begin
            @(negedge clk);
            case (readyMode)
                0:       mem_ready = ($urandom_range(0, 3) != 0);
                1:       mem_ready = 1'b1;
                default: mem_ready = 1'b0;
            endcase
            if (rst) begin
                prevStall = 1'b0;
                continue;
            end
            checkOutput("req_ready", 32'(req_ready), 32'(writeQ.size() == 0));
            checkOutput("mem_we_busy", 32'(mem_we), 32'(writeQ.size() != 0));
            if (expectDone) begin
                checkOutput("done_pulse", 32'(done), 32'd1);
                t = (doneQ.size() != 0) ? doneQ.pop_front() : 1'b0;
                checkOutput("trunc_err", 32'(trunc_err), 32'(t));
                expectDone = 1'b0;
            end else begin
                if (done) checkOutput("unexpected_done", 32'(done), 32'd0);
                if (trunc_err) checkOutput("stray_trunc_err", 32'(trunc_err), 32'd0);
            end
            if (prevStall) begin
                checkOutput("stall_we", 32'(mem_we), 32'd1);
                checkOutput("stall_addr", 32'(mem_addr), 32'(prevAddr));
                checkOutput("stall_wdata", 32'(mem_wdata), 32'(prevData));
            end
            if (mem_we && mem_ready) begin
                if (writeQ.size() == 0) begin
                    checkOutput("write_without_request", 32'(mem_we), 32'd0);
                end else begin
                    w = writeQ.pop_front();
                    checkOutput("mem_addr", 32'(mem_addr), 32'(w[31:8]));
                    checkOutput("mem_wdata", 32'(mem_wdata), 32'(w[7:0]));
                    if (writeQ.size() == 0) expectDone = 1'b1;
                end
            end
            prevStall = mem_we && !mem_ready;
            prevAddr  = mem_addr;
            prevData  = mem_wdata;
        end
    end

    // Driver: directed scenarios first, then a randomized run.
    initial begin
        logic [23:0] d;
        logic [23:0] a;
        logic [7:0]  b;
        bit          isWord;

        $display("[TB] start");
        readyMode = 1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
        checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("reset_mem_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_trunc_err", 32'(trunc_err), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Word store with the memory always ready: three consecutive writes,
        // then done one cycle later without a truncation flag.
        applyStimulus(24'h000010, 24'hA1B2C3, 1'b1);
        checkOutput("t1_b0_addr", 32'(mem_addr), 32'h10);
        checkOutput("t1_b0_data", 32'(mem_wdata), 32'hC3);
        checkOutput("t1_b0_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("t1_b1_addr", 32'(mem_addr), 32'h11);
        checkOutput("t1_b1_data", 32'(mem_wdata), 32'hB2);
        @(posedge clk);
        #1;
        checkOutput("t1_b2_addr", 32'(mem_addr), 32'h12);
        checkOutput("t1_b2_data", 32'(mem_wdata), 32'hA1);
        @(posedge clk);
        #1;
        checkOutput("t1_done", 32'(done), 32'd1);
        checkOutput("t1_trunc", 32'(trunc_err), 32'd0);
        checkOutput("t1_we_off", 32'(mem_we), 32'd0);

        // Byte stores: one that truncates and one that fits.
        applyStimulus(24'h004000, 24'h000123, 1'b0);
        checkOutput("t2a_data", 32'(mem_wdata), 32'h23);
        @(posedge clk);
        #1;
        checkOutput("t2a_done", 32'(done), 32'd1);
        checkOutput("t2a_trunc", 32'(trunc_err), 32'd1);
        applyStimulus(24'h004001, 24'hFFFF85, 1'b0);
        checkOutput("t2b_data", 32'(mem_wdata), 32'h85);
        @(posedge clk);
        #1;
        checkOutput("t2b_done", 32'(done), 32'd1);
        checkOutput("t2b_trunc", 32'(trunc_err), 32'd0);
        applyStimulus(24'h004002, 24'hFFFF80, 1'b0);
        applyStimulus(24'h004003, 24'h00007F, 1'b0);
        applyStimulus(24'h004004, 24'h000080, 1'b0);
        applyStimulus(24'h004005, 24'hFFFF7F, 1'b0);

        // Memory stalls for four cycles while the second byte is presented.
        applyStimulus(24'h123456, 24'h5A6B7C, 1'b1);
        waitWriteQSize(2);
        readyMode = 2;
        repeat (4) @(posedge clk);
        #1;
        readyMode = 1;
        waitWriteQSize(0);
        idleCycles(2);

        // Address wrap across the top of the address space.
        applyStimulus(24'hFFFFFE, 24'h0D0E0F, 1'b1);
        waitWriteQSize(0);
        idleCycles(1);

        // Back-to-back requests with junk on the request inputs while busy.
        applyStimulus(24'h000200, 24'h111111, 1'b1);
        applyStimulus(24'h000300, 24'h222222, 1'b1);
        applyStimulus(24'h000400, 24'h000042, 1'b0);
        applyStimulus(24'h000500, 24'h333333, 1'b1);
        waitWriteQSize(0);
        idleCycles(2);

        // Reset while the second byte of a word store is presented: nothing
        // more is written and no done appears; a fresh request still works.
        applyStimulus(24'h00ABC0, 24'h778899, 1'b1);
        waitWriteQSize(2);
        #1;
        readyMode = 2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        writeQ.delete();
        doneQ.delete();
        expectDone = 1'b0;
        checkOutput("rst_mid_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mid_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_mid_done", 32'(done), 32'd0);
        rst = 1'b0;
        readyMode = 1;
        idleCycles(3);
        applyStimulus(24'h00ABD0, 24'h445566, 1'b1);
        waitWriteQSize(0);
        idleCycles(2);

        // Randomized run with a stalling memory and idle gaps.
        readyMode = 0;
        for (int i = 0; i < 200; i++) begin
            b = 8'($urandom);
            d = ($urandom_range(0, 1) != 0) ? 24'($urandom) : {{16{b[7]}}, b};
            a = ($urandom_range(0, 7) == 0) ? (24'hFFFFFD + 24'($urandom_range(0, 2)))
                                             : 24'($urandom);
            isWord = 1'($urandom_range(0, 1));
            applyStimulus(a, d, isWord);
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
        end
        waitWriteQSize(0);
        idleCycles(4);
        checkOutput("done_queue_drained", 32'(doneQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
